// File: rtl/data_sram_like_slave_pkg.sv
// Shared definitions for the data-side SRAM-like responder: access-size codes,
// FSM state encoding and the byte-lane helper used by the enable generator.
package data_sram_like_slave_pkg;

  // Access size codes carried on data_size (2'b11 is handled as a word).
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Responder FSM encodings (2 bits).
  typedef enum logic [1:0] {
    DSL_IDLE = 2'b00,
    DSL_WAIT = 2'b01,
    DSL_RESP = 2'b10
  } dsl_state_e;

  // Result of decoding one access: lane enables plus the misalignment flag.
  typedef struct packed {
    logic [3:0] be;
    logic       misaligned;
  } be_info_t;

  // Lane enables and misalignment for a given size and byte offset.
  // A half on an odd offset, or a word on any non-zero offset, is misaligned.
  function automatic be_info_t calc_be(input logic [1:0] size, input logic [1:0] off);
    be_info_t info;
    info.be         = 4'b0000;
    info.misaligned = 1'b0;
    case (size)
      SIZE_BYTE: info.be = 4'b0001 << off;
      SIZE_HALF: begin
        info.be         = 4'b0011 << off;
        info.misaligned = off[0];
      end
      default: begin
        info.be         = 4'b1111;
        info.misaligned = |off;
      end
    endcase
    return info;
  endfunction

endpackage

// File: rtl/data_sram_like_slave_be_gen.sv
// Byte-enable generator: (size, byte offset) -> {be[3:0], misaligned}.
// Purely combinational; also used by the AXI bridge to build wstrb.
module data_sram_be_gen
  import data_sram_like_slave_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] off_i,
  output logic [3:0] be_o,
  output logic       misaligned_o
);

  be_info_t info;

  // Decode the access into lane enables and the misalignment flag.
  always_comb begin
    info         = calc_be(size_i, off_i);
    be_o         = info.be;
    misaligned_o = info.misaligned;
  end

endmodule

// File: rtl/data_sram_like_slave.sv
// Responder end of the CPU data-side SRAM-like port. One transaction at a
// time, backed by a word-organised RAM, completion after LATENCY cycles.
module data_sram_like_slave
  import data_sram_like_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2    // legal 1..15
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        misalign
);

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  // Word-organised storage; upper address bits alias onto the same words.
  logic [31:0] mem [DEPTH];

  dsl_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic [3:0]            be;
  logic                  mis;
  logic                  handshake;
  logic                  wr_en;
  logic [31:0]           mem_rd;
  logic                  enter_resp;
  logic                  rsp_wr;
  logic [31:0]           rsp_word;
  logic                  unused_addr_bits;

  assign idx              = data_addr[ADDR_WIDTH+1:2];
  assign off              = data_addr[1:0];
  assign unused_addr_bits = ^data_addr[31:ADDR_WIDTH+2];
  assign mem_rd           = mem[idx];

  data_sram_be_gen u_be_gen (
    .size_i       (data_size),
    .off_i        (off),
    .be_o         (be),
    .misaligned_o (mis)
  );

  // Handshake happens on the edge where a request meets data_addr_ok.
  assign handshake = data_addr_ok;
  assign wr_en     = handshake & data_wr & ~mis;

  // State register plus the per-transaction datapath registers.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q    <= DSL_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      cap_q      <= 32'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the values from before this edge.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE (WAIT skipped at LATENCY=1).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      DSL_IDLE: if (handshake) state_d = (LATENCY == 1) ? DSL_RESP : DSL_WAIT;
      DSL_WAIT: if (cnt_q <= 4'd1) state_d = DSL_RESP;
      DSL_RESP: state_d = DSL_IDLE;
      default:  state_d = DSL_IDLE;
    endcase
  end

  // Datapath next values: latency counter, captured transaction, read data.
  always_comb begin
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    cap_d      = cap_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;

    if (handshake) begin
      cnt_d = LAT_M1;
      wr_d  = data_wr;
      if (!data_wr) cap_d = mem_rd;
      if (mis) misalign_d = 1'b1;
    end else if (state_q == DSL_WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    // On the edge that enters RESP, publish the read word. With LATENCY=1
    // that edge is the handshake itself, so take the live request and RAM
    // word instead of the captured copies.
    enter_resp = (state_d == DSL_RESP) && (state_q != DSL_RESP);
    rsp_wr     = (state_q == DSL_IDLE) ? data_wr : wr_q;
    rsp_word   = (state_q == DSL_IDLE) ? mem_rd  : cap_q;
    if (enter_resp && !rsp_wr) rdata_d = rsp_word;
  end

  // Output logic: addr_ok only in IDLE outside reset, data_ok for RESP.
  always_comb begin
    data_addr_ok = (state_q == DSL_IDLE) & data_req & ~cpu_rst;
    data_data_ok = (state_q == DSL_RESP);
    data_rdata   = rdata_q;
    misalign     = misalign_q;
  end

  // RAM write port with per-lane enables; misaligned writes are dropped.
  always_ff @(posedge cpu_clk_50M) begin
    // NOTE: the RAM has no reset on purpose; contents survive cpu_rst and a
    // reset-free array maps onto block RAM.
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
      end
    end
  end

endmodule
